// File: rtl/ndp_pkg.sv
// Shared NDP definitions: drain FSM states and the serial word width.
// The core's input side uses the same 32-bit word width.
package ndp_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/ndp_rise_detect.sv
// Registered rising-edge detector for the core's calc_done level.
// prev resets to 0, so a level that is already high when reset is released
// is seen as a rise on the first clock.
module ndp_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  // Remember last cycle's level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/ndp_result_drain.sv
// Captures the NDP_core result matrix on a calc_done rise and streams it out
// as 32-bit words, LSB word first, over a valid/ready handshake.
module ndp_result_drain
  import ndp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int SYS_HEIGHT = 1,
  parameter int SYS_WIDTH  = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    calc_done_flag,
  input  logic [SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH*WIDTH-1:0] in_c,
  output logic [WORD_W-1:0]                       data_out,
  output logic                                    data_out_valid,
  input  logic                                    data_out_ready,
  output logic                                    data_out_last,
  output logic                                    row_end,
  output logic                                    busy,
  output logic                                    drain_done,
  output logic                                    overrun
);

  localparam int R      = SYS_HEIGHT * ARR_HEIGHT;
  localparam int C      = SYS_WIDTH * ARR_WIDTH;
  localparam int NWORDS = R * C * WIDTH / WORD_W;
  localparam int WPR    = C * WIDTH / WORD_W;
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  // A matrix row must split into whole words, otherwise row_end is meaningless.
  generate
    if ((C * WIDTH) % WORD_W != 0) begin : g_width_check
      $error("ndp_result_drain: C*WIDTH must be a multiple of 32");
    end
  endgenerate

  state_t                         state;
  logic [IW-1:0]                  idx;
  logic [NWORDS-1:0][WORD_W-1:0]  shadow;
  logic                           rise;
  logic                           accept;
  logic                           at_last;

  ndp_rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .level (calc_done_flag),
    .rise  (rise)
  );

  assign data_out_valid = (state == SEND);
  assign busy           = data_out_valid;
  assign accept         = data_out_valid & data_out_ready;
  assign at_last        = (idx == IW'(NWORDS - 1));
  assign data_out_last  = data_out_valid & at_last;
  assign row_end        = data_out_valid & (((int'(idx) + 1) % WPR) == 0);
  // Word mux is driven only while sending so the bus reads 0 when idle.
  assign data_out       = data_out_valid ? shadow[idx] : '0;

  // Drain FSM: capture on rise in IDLE, step the word index on each accept,
  // flag a rise that arrives mid-transfer as a sticky overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      shadow     <= '0;
      drain_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            shadow <= in_c;
            idx    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (rise) overrun <= 1'b1;
          if (accept) begin
            if (at_last) begin
              state      <= IDLE;
              idx        <= '0;
              drain_done <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ndp_result_drain.sv
// Directed bench for ndp_result_drain with an expected-word scoreboard.
module tb_ndp_result_drain;

  localparam int W  = 16;
  localparam int NE = 16;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          calc_done_flag = 1'b0;
  logic          data_out_ready = 1'b0;
  logic [NE*W-1:0] in_c = '0;
  logic [31:0]   data_out;
  logic          data_out_valid, data_out_last, row_end, busy, drain_done, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] el [NE];

  typedef struct {
    logic [31:0] data;
    logic        re;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ndp_result_drain dut (
    .clk            (clk),
    .reset          (reset),
    .calc_done_flag (calc_done_flag),
    .in_c           (in_c),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_last  (data_out_last),
    .row_end        (row_end),
    .busy           (busy),
    .drain_done     (drain_done),
    .overrun        (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_matrix(input logic [15:0] base, input logic [15:0] step);
    for (int i = 0; i < NE; i++) begin
      el[i] = base + 16'(i) * step;
      in_c[W*i +: W] = el[i];
    end
  endtask

  // Two 16-bit elements per word, lower element in the low half; two words per row.
  task automatic push_expected();
    exp_t e;
    for (int w = 0; w < NW; w++) begin
      e.data = {el[2*w+1], el[2*w]};
      e.re   = (w % 2 == 1);
      e.last = (w == NW - 1);
      exp_q.push_back(e);
    end
  endtask

  // pat 0: ready always high; pat 1: ready 1,0,0,1 repeating.
  // ev 1: scribble in_c, 2: drop then re-raise the flag, 3: reset, 4: drop the flag.
  task automatic drain(input int pat, input int ev, input int ev_at, output int acc);
    exp_t        e;
    logic [31:0] held;
    logic        stalled;
    int          cyc;
    int          stage;
    stalled = 1'b0;
    held    = '0;
    cyc     = 0;
    stage   = 0;
    acc     = 0;
    while (acc < NW && cyc < 100) begin
      @(negedge clk);
      chk("valid", data_out_valid, 1'b1);
      if (!data_out_valid || exp_q.size() == 0) break;
      e = exp_q[0];
      chk("data", data_out, e.data);
      chk("row_end", row_end, e.re);
      chk("last", data_out_last, e.last);
      chk("busy", busy, 1'b1);
      chk("no_done_mid", drain_done, 1'b0);
      if (stalled) chk("hold", data_out, held);
      if (ev == 2 && stage == 1) begin
        calc_done_flag = 1'b1;
        stage = 2;
      end
      if (acc == ev_at && stage == 0) begin
        stage = 1;
        case (ev)
          1: for (int i = 0; i < NE; i++) in_c[W*i +: W] = 16'hdead;
          2, 4: calc_done_flag = 1'b0;
          3: begin
            reset = 1'b0;
            #1;
            chk("rst_valid", data_out_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_data", data_out, 32'h0);
            chk("rst_done", drain_done, 1'b0);
            chk("rst_overrun", overrun, 1'b0);
            exp_q.delete();
            acc = -1;
            return;
          end
          default: ;
        endcase
      end
      data_out_ready = (pat == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      cyc++;
      if (data_out_ready) begin
        void'(exp_q.pop_front());
        acc++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = data_out;
      end
    end
    chk("accepts", 32'(acc), 32'(NW));
  endtask

  // Checks the drain_done pulse; optionally raises the flag in the pulse cycle.
  task automatic post_drain(input bit raise);
    @(negedge clk);
    chk("drain_done", drain_done, 1'b1);
    chk("idle_valid", data_out_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_last", data_out_last, 1'b0);
    if (raise) begin
      calc_done_flag = 1'b1;
      push_expected();
    end else begin
      @(negedge clk);
      chk("done_pulse_len", drain_done, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    data_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_valid", data_out_valid, 1'b0);
    chk("reset_data", data_out, 32'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", drain_done, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    chk("reset_row_end", row_end, 1'b0);
    chk("reset_last", data_out_last, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_no_flag", data_out_valid, 1'b0);

    // Basic drain, elements 1..16, then flag held high for 20 more cycles.
    set_matrix(16'h0001, 16'h0001);
    calc_done_flag = 1'b1;
    push_expected();
    drain(0, 0, -1, acc);
    post_drain(1'b0);
    repeat (20) begin
      @(negedge clk);
      chk("held_valid", data_out_valid, 1'b0);
      chk("held_done", drain_done, 1'b0);
    end
    calc_done_flag = 1'b0;
    @(negedge clk);
    chk("overrun_clean", overrun, 1'b0);

    // Backpressure with ready pattern 1,0,0,1.
    set_matrix(16'h0100, 16'h0011);
    calc_done_flag = 1'b1;
    push_expected();
    drain(1, 0, -1, acc);
    post_drain(1'b0);
    calc_done_flag = 1'b0;
    data_out_ready = 1'b1;
    @(negedge clk);

    // in_c scribbled mid-transfer: output keeps the captured matrix.
    set_matrix(16'h2000, 16'h0101);
    calc_done_flag = 1'b1;
    push_expected();
    drain(0, 1, 2, acc);
    post_drain(1'b0);
    calc_done_flag = 1'b0;
    @(negedge clk);

    // Second rise at word 3: overrun, original data, no second drain.
    set_matrix(16'h3000, 16'h0003);
    calc_done_flag = 1'b1;
    push_expected();
    drain(0, 2, 3, acc);
    post_drain(1'b0);
    chk("overrun_set", overrun, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_second_drain", data_out_valid, 1'b0);
    end
    chk("overrun_sticky", overrun, 1'b1);
    calc_done_flag = 1'b0;
    @(negedge clk);

    // Reset at word 4 with the flag still high: abort, then a fresh drain.
    set_matrix(16'h4000, 16'h0005);
    calc_done_flag = 1'b1;
    push_expected();
    drain(0, 3, 4, acc);
    @(negedge clk);
    chk("abort_no_done", drain_done, 1'b0);
    chk("abort_valid", data_out_valid, 1'b0);
    reset = 1'b1;
    push_expected();
    drain(0, 0, -1, acc);
    post_drain(1'b0);
    calc_done_flag = 1'b0;
    @(negedge clk);

    // Rise in the drain_done cycle is accepted straight away.
    set_matrix(16'h5000, 16'h0001);
    calc_done_flag = 1'b1;
    push_expected();
    drain(0, 4, 2, acc);
    set_matrix(16'h6000, 16'h0007);
    post_drain(1'b1);
    drain(0, 0, -1, acc);
    post_drain(1'b0);
    chk("final_overrun", overrun, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
